adat_frame_scheduler: RTL and testbench



---
 rtl/adat_frame_scheduler.sv | 140 ++++++++++++++
 tb/tb_adat_frame_scheduler.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adat_frame_scheduler.sv
// ADAT frame scheduler: paces one 8-channel sample set per frame slot, hands it to the
// generator with a start pulse, and tracks underruns, overruns and completed frames.
module adat_frame_scheduler #(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int SAMPLE_RATE = 48000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [23:0] s_audio [0:7],
   input  logic [3:0]  s_user,
   output logic [23:0] gen_audio [0:7],
   output logic [3:0]  gen_user,
   output logic        gen_start,
   input  logic        gen_frame_done,
   output logic        busy,
   output logic [15:0] underrun_count,
   output logic        overrun,
   output logic [15:0] frames_sent
);

   localparam int FRAME_PERIOD = CLK_FREQ / SAMPLE_RATE;
   localparam int CW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_PERIOD - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_TICK = 3'd1,
      LOAD      = 3'd2,
      START     = 3'd3,
      WAIT_DONE = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   underrun_q, underrun_d;
   logic [15:0]   frames_q, frames_d;
   logic          overrun_q, overrun_d;
   logic          s_ready_q, gen_start_q, busy_q;
   logic [3:0]    gen_user_q, gen_user_d;
   logic [23:0]   gen_audio_q [0:7];
   logic [23:0]   gen_audio_d [0:7];
   logic          tick;
   logic          in_frame;

   // The slot grid only runs outside IDLE, so a stale count can never fire a tick there.
   assign tick     = (state_q != IDLE) && (cnt_q == CNT_MAX);
   assign in_frame = (state_q == LOAD) || (state_q == START) || (state_q == WAIT_DONE);

   always_comb begin
      state_d    = state_q;
      underrun_d = underrun_q;
      frames_d   = frames_q;
      overrun_d  = overrun_q;
      gen_user_d = gen_user_q;

      case (state_q)
         IDLE: begin
            if (enable) state_d = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (tick) state_d = enable ? LOAD : IDLE;
         end
         LOAD: begin
            state_d    = START;
            gen_user_d = s_valid ? s_user : 4'd0;
            if (!s_valid && (underrun_q != 16'hFFFF)) underrun_d = underrun_q + 16'd1;
         end
         START: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (gen_frame_done) begin
               frames_d = frames_q + 16'd1;
               state_d  = enable ? WAIT_TICK : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A slot that lands while a frame is still in flight is dropped, never queued.
      if (tick && in_frame) overrun_d = 1'b1;

      if ((state_q == IDLE) || (state_d == IDLE)) cnt_d = '0;
      else if (tick)                              cnt_d = '0;
      else                                        cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         underrun_q  <= 16'd0;
         frames_q    <= 16'd0;
         overrun_q   <= 1'b0;
         s_ready_q   <= 1'b0;
         gen_start_q <= 1'b0;
         busy_q      <= 1'b0;
         gen_user_q  <= 4'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         underrun_q  <= underrun_d;
         frames_q    <= frames_d;
         overrun_q   <= overrun_d;
         s_ready_q   <= (state_d == LOAD);
         gen_start_q <= (state_d == START);
         busy_q      <= (state_d != IDLE);
         gen_user_q  <= gen_user_d;
      end
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_chan
      // Underrun slots send silence rather than repeating the previous frame.
      always_comb begin
         gen_audio_d[gi] = gen_audio_q[gi];
         if (state_q == LOAD) gen_audio_d[gi] = s_valid ? s_audio[gi] : 24'd0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) gen_audio_q[gi] <= 24'd0;
         else        gen_audio_q[gi] <= gen_audio_d[gi];
      end

      assign gen_audio[gi] = gen_audio_q[gi];
   end

   assign s_ready        = s_ready_q;
   assign gen_start      = gen_start_q;
   assign gen_user       = gen_user_q;
   assign busy           = busy_q;
   assign underrun_count = underrun_q;
   assign overrun        = overrun_q;
   assign frames_sent    = frames_q;

endmodule

// File: tb/tb_adat_frame_scheduler.sv
// Bench for adat_frame_scheduler: upstream source, generator model and per-scenario
// checks against slot-level expectations (start times, frame contents, counters).
module tb_adat_frame_scheduler;

   localparam int CLK_FREQ    = 4_800_000;
   localparam int SAMPLE_RATE = 48000;
   localparam int FP          = CLK_FREQ / SAMPLE_RATE;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        s_valid;
   logic        s_ready;
   logic [23:0] s_audio [0:7];
   logic [3:0]  s_user;
   logic [23:0] gen_audio [0:7];
   logic [3:0]  gen_user;
   logic        gen_start;
   logic        gen_frame_done;
   logic        busy;
   logic [15:0] underrun_count;
   logic        overrun;
   logic [15:0] frames_sent;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Upstream model: one prepared sample set per slot.
   logic [191:0] slot_data  [0:15];
   logic [3:0]   slot_user  [0:15];
   bit           slot_valid [0:15];
   int           slot_idx;

   // Generator model and recorder state.
   int           gen_lat = 90;
   bit           spurious = 1'b0;
   int           done_pend = 0;
   int           start_cyc   [$];
   logic [191:0] start_audio [$];
   logic [3:0]   start_user  [$];
   int           b2b = 0;
   int           hold_bad = 0;
   bit           prev_start = 1'b0;
   bit           prev_ready = 1'b0;
   bit           prev_rst = 1'b0;
   logic [191:0] prev_audio = '0;

   adat_frame_scheduler #(
      .CLK_FREQ   (CLK_FREQ),
      .SAMPLE_RATE(SAMPLE_RATE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_audio       (s_audio),
      .s_user        (s_user),
      .gen_audio     (gen_audio),
      .gen_user      (gen_user),
      .gen_start     (gen_start),
      .gen_frame_done(gen_frame_done),
      .busy          (busy),
      .underrun_count(underrun_count),
      .overrun       (overrun),
      .frames_sent   (frames_sent)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [191:0] pack_gen();
      logic [191:0] v;
      for (int i = 0; i < 8; i++) v[24*i +: 24] = gen_audio[i];
      return v;
   endfunction

   always @(negedge clk) begin
      logic [191:0] cur;
      bit fire;
      if (gen_start) begin
         start_cyc.push_back(cyc);
         start_audio.push_back(pack_gen());
         start_user.push_back(gen_user);
         if (prev_start) b2b++;
      end
      prev_start = gen_start;
      cur = pack_gen();
      if (rst_n && prev_rst && !prev_ready && (cur != prev_audio)) hold_bad++;
      prev_audio = cur;
      prev_ready = s_ready;
      prev_rst   = rst_n;

      fire = 1'b0;
      if (!rst_n) begin
         done_pend = 0;
      end else begin
         if (done_pend > 0) begin
            done_pend--;
            if (done_pend == 0) fire = 1'b1;
         end
         if (gen_start) done_pend = gen_lat;
      end
      gen_frame_done = fire | spurious;
      spurious = 1'b0;

      if (s_ready) begin
         s_valid = slot_valid[slot_idx % 16];
         for (int i = 0; i < 8; i++) s_audio[i] = slot_data[slot_idx % 16][24*i +: 24];
         s_user = slot_user[slot_idx % 16];
         slot_idx++;
      end else begin
         s_valid = 1'($urandom);
         for (int i = 0; i < 8; i++) s_audio[i] = 24'($urandom);
         s_user = 4'($urandom);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      start_cyc.delete();
      start_audio.delete();
      start_user.delete();
      b2b      = 0;
      hold_bad = 0;
      slot_idx = 0;
      rst_n    = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_starts(input int n, input int budget, output bit ok);
      int k = 0;
      while ((start_cyc.size() < n) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      ok = (start_cyc.size() >= n);
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int k = 0;
      while (busy && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      ok = !busy;
   endtask

   task automatic fill_slots(input bit fixed_pattern);
      for (int k = 0; k < 16; k++) begin
         slot_valid[k] = 1'b1;
         slot_user[k]  = fixed_pattern ? 4'(k) : 4'($urandom);
         for (int i = 0; i < 8; i++)
            slot_data[k][24*i +: 24] = fixed_pattern ? 24'(24'h100000 + i) : 24'($urandom);
      end
   endtask

   // Leaving IDLE takes one edge, the first tick lands FP clocks later, then LOAD -> START.
   function automatic int first_start(input int en_cyc);
      return en_cyc + 1 + FP + 1;
   endfunction

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
      checks++; if (gen_start !== 1'b0) begin errors++; $display("FAIL reset_gen_start: got %b want 0", gen_start); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL reset_underrun: got %0d want 0", underrun_count); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frames_sent); end
      checks++; if (pack_gen() !== 192'd0) begin errors++; $display("FAIL reset_gen_audio: got %h want 0", pack_gen()); end
      checks++; if (gen_user !== 4'd0) begin errors++; $display("FAIL reset_gen_user: got %h want 0", gen_user); end
      $display("test_reset: done");
   endtask

   task automatic test_nominal();
      int en_cyc;
      bit ok;
      fill_slots(1'b1);
      gen_lat = 90;
      do_reset();
      enable = 1'b1;
      en_cyc = cyc;
      wait_starts(10, 12 * FP, ok);
      enable = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL nominal_starts: got %0d starts want 10", start_cyc.size()); end
      if (ok) begin
         checks++;
         if (start_cyc[0] !== first_start(en_cyc)) begin
            errors++; $display("FAIL nominal_first_start: got cycle %0d want %0d", start_cyc[0], first_start(en_cyc));
         end
         for (int k = 1; k < 10; k++) begin
            checks++;
            if (start_cyc[k] - start_cyc[k-1] !== FP) begin
               errors++; $display("FAIL nominal_spacing[%0d]: got %0d want %0d", k, start_cyc[k] - start_cyc[k-1], FP);
            end
         end
         for (int k = 0; k < 10; k++) begin
            checks++;
            if ((start_audio[k][72 +: 24] !== 24'h100003) || (start_audio[k] !== slot_data[k])) begin
               errors++; $display("FAIL nominal_audio[%0d]: got %h want %h", k, start_audio[k], slot_data[k]);
            end
            checks++;
            if (start_user[k] !== slot_user[k]) begin
               errors++; $display("FAIL nominal_user[%0d]: got %h want %h", k, start_user[k], slot_user[k]);
            end
         end
      end
      wait_idle(2 * FP, ok);
      checks++; if (!ok) begin errors++; $display("FAIL nominal_idle: busy still %b want 0", busy); end
      checks++; if (frames_sent !== 16'd10) begin errors++; $display("FAIL nominal_frames: got %0d want 10", frames_sent); end
      checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL nominal_underrun: got %0d want 0", underrun_count); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL nominal_overrun: got %b want 0", overrun); end
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL nominal_hold: got %0d changes want 0", hold_bad); end
      $display("test_nominal: %0d frames", start_cyc.size());
   endtask

   task automatic test_underrun();
      bit ok;
      logic [191:0] exp_a;
      logic [3:0] exp_u;
      fill_slots(1'b0);
      slot_valid[2] = 1'b0;
      slot_valid[3] = 1'b0;
      gen_lat = 90;
      do_reset();
      enable = 1'b1;
      wait_starts(6, 8 * FP, ok);
      enable = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL underrun_starts: got %0d starts want 6", start_cyc.size()); end
      if (ok) begin
         for (int k = 0; k < 6; k++) begin
            exp_a = slot_valid[k] ? slot_data[k] : 192'd0;
            exp_u = slot_valid[k] ? slot_user[k] : 4'd0;
            checks++;
            if ((start_audio[k] !== exp_a) || (start_user[k] !== exp_u)) begin
               errors++; $display("FAIL underrun_frame[%0d]: got %h/%h want %h/%h", k, start_audio[k], start_user[k], exp_a, exp_u);
            end
            if (k > 0) begin
               checks++;
               if (start_cyc[k] - start_cyc[k-1] !== FP) begin
                  errors++; $display("FAIL underrun_spacing[%0d]: got %0d want %0d", k, start_cyc[k] - start_cyc[k-1], FP);
               end
            end
         end
      end
      wait_idle(2 * FP, ok);
      checks++; if (underrun_count !== 16'd2) begin errors++; $display("FAIL underrun_count: got %0d want 2", underrun_count); end
      checks++; if (frames_sent !== 16'd6) begin errors++; $display("FAIL underrun_frames: got %0d want 6", frames_sent); end
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL underrun_hold: got %0d changes want 0", hold_bad); end
      $display("test_underrun: underruns=%0d", underrun_count);
   endtask

   task automatic test_overrun();
      bit ok;
      int s;
      fill_slots(1'b0);
      gen_lat = 150;
      do_reset();
      enable = 1'b1;
      wait_starts(1, 2 * FP, ok);
      checks++; if (!ok) begin errors++; $display("FAIL overrun_first_start: none within %0d cycles", 2 * FP); end
      if (ok) begin
         s = start_cyc[0];
         // The next slot tick lands FP-2 cycles after the start cycle; overrun is visible one cycle later.
         while (cyc < s + FP - 3) @(negedge clk);
         checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b want 0", overrun); end
         while (cyc < s + FP + 2) @(negedge clk);
         checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
      end
      wait_starts(3, 8 * FP, ok);
      enable = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL overrun_starts: got %0d starts want 3", start_cyc.size()); end
      if (ok) begin
         for (int k = 1; k < 3; k++) begin
            checks++;
            if (start_cyc[k] - start_cyc[k-1] !== 2 * FP) begin
               errors++; $display("FAIL overrun_spacing[%0d]: got %0d want %0d", k, start_cyc[k] - start_cyc[k-1], 2 * FP);
            end
         end
      end
      wait_idle(3 * FP, ok);
      checks++; if (b2b !== 0) begin errors++; $display("FAIL overrun_b2b: got %0d back-to-back starts want 0", b2b); end
      checks++; if (frames_sent !== 16'd3) begin errors++; $display("FAIL overrun_frames: got %0d want 3", frames_sent); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
      $display("test_overrun: overrun=%b", overrun);
   endtask

   task automatic test_enable_drop();
      bit ok;
      int s;
      fill_slots(1'b0);
      gen_lat = 90;
      do_reset();
      enable = 1'b1;
      wait_starts(1, 2 * FP, ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_first_start: none within %0d cycles", 2 * FP); end
      s = ok ? start_cyc[0] : cyc;
      while (cyc < s + 10) @(negedge clk);
      enable = 1'b0;
      while (cyc < s + 50) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_in_flight_busy: got %b want 1", busy); end
      wait_idle(2 * FP, ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_idle: busy still %b want 0", busy); end
      checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL drop_frames: got %0d want 1", frames_sent); end
      repeat (2 * FP) @(negedge clk);
      checks++; if (start_cyc.size() !== 1) begin errors++; $display("FAIL drop_no_more_starts: got %0d starts want 1", start_cyc.size()); end
      checks++; if ((busy !== 1'b0) || (s_ready !== 1'b0)) begin errors++; $display("FAIL drop_quiet: busy=%b s_ready=%b want 0/0", busy, s_ready); end
      $display("test_enable_drop: frames=%0d", frames_sent);
   endtask

   task automatic test_reset_mid();
      bit ok;
      int s;
      int en_cyc;
      fill_slots(1'b0);
      gen_lat = 90;
      do_reset();
      enable = 1'b1;
      wait_starts(1, 2 * FP, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_first_start: none within %0d cycles", 2 * FP); end
      s = ok ? start_cyc[0] : cyc;
      while (cyc < s + 20) @(negedge clk);
      #2 rst_n = 1'b0;
      start_cyc.delete();
      #1;
      checks++; if ((busy !== 1'b0) || (gen_start !== 1'b0) || (s_ready !== 1'b0)) begin
         errors++; $display("FAIL rstmid_ctrl: busy=%b gen_start=%b s_ready=%b want 0/0/0", busy, gen_start, s_ready);
      end
      checks++; if ((pack_gen() !== 192'd0) || (gen_user !== 4'd0)) begin
         errors++; $display("FAIL rstmid_data: got %h/%h want 0/0", pack_gen(), gen_user);
      end
      checks++; if ((frames_sent !== 16'd0) || (underrun_count !== 16'd0) || (overrun !== 1'b0)) begin
         errors++; $display("FAIL rstmid_counters: frames=%0d underrun=%0d overrun=%b want 0/0/0", frames_sent, underrun_count, overrun);
      end
      repeat (3) @(negedge clk);
      checks++; if (start_cyc.size() !== 0) begin errors++; $display("FAIL rstmid_no_start: got %0d starts want 0", start_cyc.size()); end
      rst_n  = 1'b1;
      en_cyc = cyc;
      wait_starts(1, 2 * FP, ok);
      checks++;
      if (!ok || (start_cyc[0] !== first_start(en_cyc))) begin
         errors++; $display("FAIL rstmid_restart: got cycle %0d want %0d", ok ? start_cyc[0] : -1, first_start(en_cyc));
      end
      enable = 1'b0;
      wait_idle(2 * FP, ok);
      checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL rstmid_frames: got %0d want 1", frames_sent); end
      $display("test_reset_mid: restart observed");
   endtask

   task automatic test_spurious();
      bit ok;
      int en_cyc;
      int s;
      fill_slots(1'b0);
      gen_lat = 90;
      do_reset();
      enable = 1'b1;
      en_cyc = cyc;
      repeat (20) @(negedge clk);
      @(posedge clk);
      spurious = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (frames_sent !== 16'd0) begin errors++; $display("FAIL spur_idle_frames: got %0d want 0", frames_sent); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL spur_busy: got %b want 1", busy); end
      wait_starts(1, 2 * FP, ok);
      checks++;
      if (!ok || (start_cyc[0] !== first_start(en_cyc))) begin
         errors++; $display("FAIL spur_start_time: got cycle %0d want %0d", ok ? start_cyc[0] : -1, first_start(en_cyc));
      end
      s = ok ? start_cyc[0] : cyc;
      while (cyc < s + 93) @(negedge clk);
      checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL spur_first_frame: got %0d want 1", frames_sent); end
      @(posedge clk);
      spurious = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (frames_sent !== 16'd1) begin errors++; $display("FAIL spur_tick_frames: got %0d want 1", frames_sent); end
      wait_starts(2, 2 * FP, ok);
      checks++;
      if (!ok || (start_cyc[1] - start_cyc[0] !== FP)) begin
         errors++; $display("FAIL spur_spacing: got %0d want %0d", ok ? start_cyc[1] - start_cyc[0] : -1, FP);
      end
      enable = 1'b0;
      wait_idle(2 * FP, ok);
      checks++; if (frames_sent !== 16'd2) begin errors++; $display("FAIL spur_frames: got %0d want 2", frames_sent); end
      $display("test_spurious: frames=%0d", frames_sent);
   endtask

   initial begin
      rst_n          = 1'b1;
      enable         = 1'b0;
      s_valid        = 1'b0;
      s_user         = 4'd0;
      gen_frame_done = 1'b0;
      slot_idx       = 0;
      for (int i = 0; i < 8; i++) s_audio[i] = 24'd0;
      test_reset();
      test_nominal();
      test_underrun();
      test_overrun();
      test_enable_drop();
      test_reset_mid();
      test_spurious();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
